dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words, a power of two, minimum 4.
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH), meaning the word-index width.
REQ-003 The block SHALL have port clk_sys  input  1  the single system clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst_sys  input  1  the reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_mem_wen  input  1  the write request from the memory-access stage.
REQ-006 The block SHALL have port i_mem_ren  input  1  the read request from the memory-access stage.
REQ-007 The block SHALL have port i_mem_addr  input  32  the byte address.
REQ-008 The block SHALL have port i_mem_wdata  input  32  the write data.
REQ-009 The block SHALL have port o_mem_rdata  output  32  the read data, registered.
REQ-010 The block SHALL have port o_init_busy  output  1  a flag that is high while the memory clear sweep runs.
REQ-011 The block SHALL have port o_mem_err  output  1  a registered one-cycle pulse flagging an access with a bad address.

Function
REQ-012 The word index SHALL be i_mem_addr[AW+1:2]; an address is bad if i_mem_addr[1:0]!=0 or any bit i_mem_addr[31:AW+2] is 1.
REQ-013 The FSM SHALL have two states, INIT and READY; reset enters INIT with sweep counter = 0.
REQ-014 In INIT, the block SHALL write 0 to mem[counter] and increment the counter every cycle; when counter==DEPTH-1 is written, the next state is READY; INIT lasts exactly DEPTH cycles.
REQ-015 o_init_busy SHALL be 1 in INIT and 0 in READY.
REQ-016 In INIT, i_mem_wen/i_mem_ren SHALL be ignored: no write, o_mem_rdata unchanged, no o_mem_err.
REQ-017 In READY, for a write with a good address, mem[index] SHALL take i_mem_wdata at the same rising edge.
REQ-018 In READY, for a read with a good address, o_mem_rdata SHALL equal mem[index] on the cycle after the request (1-cycle latency, matching the write-back stage's sampling).
REQ-019 o_mem_rdata SHALL hold its value until the next accepted read.
REQ-020 In READY, for an access with a bad address, writes SHALL be dropped, a read SHALL load 0 into o_mem_rdata, and o_mem_err SHALL be 1 for exactly the following cycle.
REQ-021 When i_mem_wen and i_mem_ren are both high in the same cycle, both SHALL be serviced; one bad address raises a single o_mem_err pulse.
REQ-022 For a same-cycle read and write to the same index, the read SHALL return the old data unless DMEM_BYPASS_EN is defined (REQ-026).
REQ-023 Back-to-back accesses SHALL be accepted every cycle, with no stall output.

Reset
REQ-024 On rst_sys low, the block SHALL force state=INIT, counter=0, o_mem_rdata=0, o_mem_err=0, o_init_busy=1, asynchronously; memory contents are not reset directly and are cleared by the sweep.
REQ-025 A reset asserted mid-sweep or mid-access SHALL abandon that activity and restart the full DEPTH-cycle sweep after release.

Configuration
REQ-026 When the macro DMEM_BYPASS_EN is defined, a same-cycle read and write to the same good index SHALL return i_mem_wdata on o_mem_rdata the next cycle; when it is undefined, the read returns the pre-write word and the block has no bypass mux.

Verification
REQ-027 Verification SHALL cover this scenario (DEPTH=16): release reset -> o_init_busy high for exactly 16 cycles, then 0; reads of all 16 words return 0x00000000.
REQ-028 Verification SHALL cover this scenario: write 0xDEADBEEF at addr 0x8, then read 0x8 the next cycle -> o_mem_rdata=0xDEADBEEF one cycle after the read request, held while i_mem_ren=0.
REQ-029 Verification SHALL cover this scenario: read addr 0x6 (misaligned) and write addr 0x40 (out of range for DEPTH=16) -> o_mem_err pulses 1 cycle each, o_mem_rdata=0, mem[0] unchanged.
REQ-030 Verification SHALL cover this scenario: mem[3]=0x11111111, same-cycle write 0x22222222 and read of addr 0xC -> 0x11111111 without DMEM_BYPASS_EN and 0x22222222 with it; a read the following cycle returns 0x22222222 in both builds.
REQ-031 Verification SHALL cover this scenario: an access during INIT (write 0x5 at 0x0) -> ignored, mem[0]=0 after the sweep, no o_mem_err.
REQ-032 Verification SHALL cover this scenario: reset asserted at sweep cycle 7 -> outputs return to their reset values immediately, and the sweep reruns a full 16 cycles after release.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Word-addressed data memory with a post-reset zero-fill sweep, 1-cycle registered reads and bad-address flagging.
// Optional macro DMEM_BYPASS_EN: a same-cycle read and write to the same word returns the new write data.
module dmem_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        i_mem_wen,
  input  logic        i_mem_ren,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_init_busy,
  output logic        o_mem_err
);

  localparam int DATA_W = 32;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       sweep_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [AW-1:0]       idx;
  logic                bad_addr;
  logic                ready;
  logic                mem_we;
  logic [AW-1:0]       mem_widx;
  logic [DATA_W-1:0]   mem_wdat;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rdata_p1;
  logic                err_p1;

  // Misaligned, or beyond the implemented word range.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (|a[31:AW+2]);
  endfunction

  assign idx      = i_mem_addr[AW+1:2];
  assign bad_addr = addr_bad(i_mem_addr);

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) state_q <= INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_init_busy = 1'b0;
    ready       = 1'b0;
    case (state_q)
      INIT: begin
        o_init_busy = 1'b1;
        if (sweep_cnt == LAST_IDX) state_d = READY;
      end
      READY: ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys)              sweep_cnt <= '0;
    else if (state_q == INIT)  sweep_cnt <= sweep_cnt + AW'(1);
  end

  // Single write port shared by the clear sweep and the access stage.
  always_comb begin
    mem_we   = 1'b0;
    mem_widx = idx;
    mem_wdat = i_mem_wdata;
    if (state_q == INIT) begin
      mem_we   = 1'b1;
      mem_widx = sweep_cnt;
      mem_wdat = '0;
    end else if (i_mem_wen && !bad_addr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (mem_we) mem[mem_widx] <= mem_wdat;
  end

`ifdef DMEM_BYPASS_EN
  // Reads and writes share one address, so a concurrent write always targets the read word.
  assign rd_word = i_mem_wen ? i_mem_wdata : mem[idx];
`else
  assign rd_word = mem[idx];
`endif

  // Stage p1: registered read data and error pulse.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      err_p1 <= ready && (i_mem_wen || i_mem_ren) && bad_addr;
      if (ready && i_mem_ren) rdata_p1 <= bad_addr ? '0 : rd_word;
    end
  end

  assign o_mem_rdata = rdata_p1;
  assign o_mem_err   = err_p1;

endmodule
